mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Bus-side memory access sequencer directly upstream of the 16-bit asynchronous RAM model.
- Accepts one read or write request at a time from the CPU datapath over a valid/ready handshake.
- Drives RAM address, write data and write enable with fixed setup, pulse and hold timing, covering the RAM's ~70 ns access time.
- Samples RAM read data after a programmable number of wait cycles and returns it with a one-cycle response strobe.

Parameters:
- RD_WAIT, 2, clock cycles Ma is held stable before Mrd is sampled (min 1).
- WR_PULSE, 2, clock cycles Mwen is held high (min 1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  request address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion strobe, reads and writes
- rsp_rdata  out  16  last read data, held until next read completes
- wr_err  out  1  readback mismatch flag, sticky (see Optional Feature)
- Ma  out  16  RAM address
- Mwd  out  16  RAM write data
- Mwen  out  1  RAM write enable
- Mrd  in  16  RAM read data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; Ma=0, Mwd=0, Mwen=0, rsp_valid=0, rsp_rdata=0, wr_err=0, wait counter 0. All outputs are registered.
- req_ready is combinational from state: 1 only in IDLE.
- Accept: edge E0 with req_valid && req_ready. Latch req_addr into Ma and req_wdata into Mwd, writes only. On reads Mwd keeps its old value.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RSP (plus VFY_WAIT when optional).
- Read:
  - IDLE→RD_WAIT at E0, counter loaded with RD_WAIT.
  - Counter decrements each edge. At edge E_RD_WAIT, sample Mrd into rsp_rdata, then go to RSP.
- Write:
  - IDLE→WR_SETUP at E0, Mwen=0.
  - WR_SETUP→WR_PULSE at E1, Mwen=1.
  - Hold Mwen=1 for WR_PULSE cycles, then go to WR_HOLD with Mwen=0.
  - WR_HOLD keeps Ma/Mwd stable for 1 cycle, then go to RSP.
- RSP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready stays 0 in RSP, so the next accept is the edge after RSP.
- Latency, accept edge to rsp_valid high:
  - read: RD_WAIT+1 cycles
  - write: WR_PULSE+3 cycles
- Ma and Mwd never change while Mwen=1, nor in the cycle before Mwen rises or after it falls.
- Requests while busy are ignored (not latched). Request inputs are don't-care outside the accept edge.
- rsp_rdata is unchanged by write completions.
- Address 0xFFFF is legal; no wrap or increment logic exists.
- Reset mid-operation: at the reset edge Mwen→0 and Ma→0 together, state→IDLE, no rsp_valid, and any in-flight result is discarded. A partially written RAM word is undefined.
- Counters are sized to hold the larger of RD_WAIT and WR_PULSE. Parameters below 1 are illegal: elaboration error via generate-time check.

Optional Feature:
- Macro MEM_SEQ_READBACK_EN.
- Defined:
  - After WR_HOLD, the FSM enters VFY_WAIT. Ma stays unchanged and Mwen=0 for RD_WAIT cycles.
  - Mrd is then compared to Mwd. On mismatch, set wr_err=1, sticky until rst.
  - Then go to RSP. Write latency grows by RD_WAIT. rsp_rdata is not updated by the verify read.
- Undefined: no VFY_WAIT state; wr_err tied 0.

Test Plan:
- Reset, then read 0x0001 with RD_WAIT=2 -> rsp_valid pulse 3 cycles after accept, rsp_rdata=0x9101, Mwen never high.
- Write 0x0200=0x1234, then read 0x0200 -> Mwen high exactly 2 cycles with Ma=0x0200 stable setup/hold, read returns 0x1234, rsp_rdata before the read still 0x9101.
- req_valid held high during a read at 0x0003 with a different addr -> req_ready=0, Ma stays 0x0003, second request accepted only after RSP, each returns its own data (0xB502, then next).
- Back-to-back reads 0x0100..0x0103 -> 0x00DE, 0x00AD, 0x00BE, 0x00EF, one rsp_valid per request, none lost.
- Assert rst during WR_PULSE of write 0x0201=0xBEEF -> next edge Mwen=0, Ma=0, req_ready=1, no rsp_valid.
- With MEM_SEQ_READBACK_EN: write 0x0100=0x5555 -> wr_err=1 and stays set. Write 0x0202=0x00AA -> wr_err unchanged, no false clear. Without the macro wr_err=0 throughout.

Source files
------------

// File: rtl/mem_sequencer.sv
// ---------------------------------------------------------------------------
// mem_sequencer
//
// Purpose:
//   Bus-side sequencer that sits directly in front of a 16-bit asynchronous
//   RAM. It takes one read or write request at a time from the CPU datapath
//   and drives the RAM address, write data and write enable with fixed setup,
//   pulse and hold timing. Read data is sampled after a programmable number
//   of wait cycles and returned with a one-cycle response strobe.
//
// Handshake:
//   A request is taken on the rising edge where req_valid && req_ready are
//   both 1. req_ready is high only while the sequencer is idle. Request
//   inputs are ignored on every other edge. Each accepted request produces
//   exactly one rsp_valid pulse that lasts a single cycle. There is no
//   back-pressure on the response side.
//
// Parameters:
//   RD_WAIT  - cycles Ma is held stable before Mrd is sampled (>= 1)
//   WR_PULSE - cycles Mwen is held high (>= 1)
//
// Optional feature (macro MEM_SEQ_READBACK_EN):
//   When defined, every write is followed by a verify read. Ma is held for
//   RD_WAIT more cycles, Mrd is compared with Mwd, and any mismatch sets the
//   sticky wr_err flag. When undefined, wr_err is tied to 0.
//
// Ports:
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   sequencer idle, can accept
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in  16   request address
//   req_wdata  in  16   write data
//   rsp_valid  out  1   one-cycle completion strobe (reads and writes)
//   rsp_rdata  out 16   last read data, held until the next read completes
//   wr_err     out  1   sticky readback mismatch flag
//   Ma         out 16   RAM address
//   Mwd        out 16   RAM write data
//   Mwen       out  1   RAM write enable
//   Mrd        in  16   RAM read data
// ---------------------------------------------------------------------------
module mem_sequencer #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        wr_err,
    output logic [15:0] Ma,
    output logic [15:0] Mwd,
    output logic        Mwen,
    input  logic [15:0] Mrd
);

    // -----------------------------------------------------------------------
    // Parameter legality. Zero-length waits would make the counters below
    // meaningless, so they are rejected at elaboration time.
    // -----------------------------------------------------------------------
    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("mem_sequencer: RD_WAIT must be at least 1");
    end
    if (WR_PULSE < 1) begin : g_bad_wr_pulse
        $error("mem_sequencer: WR_PULSE must be at least 1");
    end

    // One shared wait counter, sized for the longer of the two waits.
    localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_LOAD     = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD     = CNT_W'(WR_PULSE);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_RSP      = 3'd5
`ifdef MEM_SEQ_READBACK_EN
        ,
        S_VFY_WAIT = 3'd6
`endif
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      ma_q;
    logic [15:0]      mwd_q;
    logic             mwen_q;
    logic             rsp_valid_q;
    logic [15:0]      rsp_rdata_q;
`ifdef MEM_SEQ_READBACK_EN
    logic             wr_err_q;
`endif

    // -----------------------------------------------------------------------
    // Sequencer FSM. All RAM-facing and response outputs are registered here.
    //
    // Read  : IDLE -> RD_WAIT (RD_WAIT cycles) -> RSP -> IDLE
    // Write : IDLE -> WR_SETUP -> WR_PULSE (WR_PULSE cycles) -> WR_HOLD
    //         [-> VFY_WAIT (RD_WAIT cycles)] -> RSP -> IDLE
    //
    // rsp_valid is registered from the RSP state, so the strobe is high in the
    // cycle that follows RSP. That cycle is already IDLE, which lets a new
    // request be taken on the same edge that ends the strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ma_q        <= '0;
            mwd_q       <= '0;
            mwen_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MEM_SEQ_READBACK_EN
            wr_err_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ma_q <= req_addr;
                        if (req_we) begin
                            // Mwd only follows write requests; a read leaves
                            // the previous write data on the bus.
                            mwd_q   <= req_wdata;
                            state_q <= S_WR_SETUP;
                        end else begin
                            cnt_q   <= RD_LOAD;
                            state_q <= S_RD_WAIT;
                        end
                    end
                end

                S_RD_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    // Last wait cycle: Ma has been stable for RD_WAIT cycles.
                    if (cnt_q == CNT_ONE) begin
                        rsp_rdata_q <= Mrd;
                        state_q     <= S_RSP;
                    end
                end

                S_WR_SETUP: begin
                    // Ma/Mwd have been stable for one full cycle; raise Mwen.
                    mwen_q  <= 1'b1;
                    cnt_q   <= WR_LOAD;
                    state_q <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        mwen_q  <= 1'b0;
                        state_q <= S_WR_HOLD;
                    end
                end

                S_WR_HOLD: begin
                    // Ma/Mwd stay put for one cycle after Mwen falls.
`ifdef MEM_SEQ_READBACK_EN
                    cnt_q   <= RD_LOAD;
                    state_q <= S_VFY_WAIT;
`else
                    state_q <= S_RSP;
`endif
                end

`ifdef MEM_SEQ_READBACK_EN
                S_VFY_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    // Verify read reuses the read access time; the result only
                    // feeds the error flag and never touches rsp_rdata.
                    if (cnt_q == CNT_ONE) begin
                        if (Mrd != mwd_q) begin
                            wr_err_q <= 1'b1;
                        end
                        state_q <= S_RSP;
                    end
                end
`endif

                S_RSP: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    mwen_q  <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign Ma        = ma_q;
    assign Mwd       = mwd_q;
    assign Mwen      = mwen_q;

`ifdef MEM_SEQ_READBACK_EN
    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_sequencer
//
// Drives mem_sequencer against a simple asynchronous RAM model. Addresses
// 0x0100-0x01FF behave as read-only storage, so writes there read back
// their original contents. Expected results come from a reference memory
// image and the latency and sticky-error rules, not from DUT state.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_sequencer;

  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 2;
`ifdef MEM_SEQ_READBACK_EN
  localparam int VFY_CYC  = RD_WAIT;
`else
  localparam int VFY_CYC  = 0;
`endif
  localparam int RD_LAT = RD_WAIT + 1;
  localparam int WR_LAT = WR_PULSE + 3 + VFY_CYC;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, wr_err, Mwen;
  logic [15:0] rsp_rdata, Ma, Mwd, Mrd;

  always #5 clk = ~clk;

  mem_sequencer #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_err(wr_err),
    .Ma(Ma), .Mwd(Mwd), .Mwen(Mwen), .Mrd(Mrd)
  );

  // ---------------- RAM model ----------------
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];

  function automatic logic is_rom(input logic [15:0] a);
    return a[15:8] == 8'h01;
  endfunction

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0001: return 16'h9101;
      16'h0003: return 16'hB502;
      16'h0100: return 16'h00DE;
      16'h0101: return 16'h00AD;
      16'h0102: return 16'h00BE;
      16'h0103: return 16'h00EF;
      default:  return a ^ 16'h5A3C;
    endcase
  endfunction

  assign Mrd = ram[Ma];
  always @(posedge clk) if (Mwen === 1'b1 && !is_rom(Ma)) ram[Ma] = Mwd;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_mwd   = 16'h0;
  logic [15:0] exp_rdata = 16'h0;
  logic        exp_err   = 1'b0;
  bit          rb_en     = (VFY_CYC != 0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        mon_on = 1'b0;
  logic        mwen_p = 1'b0, rst_p = 1'b1, rsp_p = 1'b0;
  logic [15:0] ma_p = 16'h0, mwd_p = 16'h0;
  int          run = 0;

  always @(negedge clk) begin
    if (mon_on && !rst_p) begin
      if (Mwen || mwen_p) begin
        check_eq("ma_stable_wr", Ma, ma_p);
        check_eq("mwd_stable_wr", Mwd, mwd_p);
      end
      if (mwen_p && !Mwen) check_eq("mwen_width", run, WR_PULSE);
      if (rsp_valid) check_eq("rsp_one_cycle", rsp_p, 0);
    end
    run    = Mwen ? run + 1 : 0;
    mwen_p = Mwen;
    ma_p   = Ma;
    mwd_p  = Mwd;
    rsp_p  = rsp_valid;
    rst_p  = rst;
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d, input bit pester);
    int  n;
    int  lat;
    bit  got;
    bit  mwen_seen;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("ready_before_req", req_ready, 1);

    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    if (!we) exp_q.push_back(ref_mem[a]);
    else begin
      exp_mwd = d;
      if (is_rom(a)) begin
        if (rb_en && d != ref_mem[a]) exp_err = 1'b1;
      end else ref_mem[a] = d;
    end

    @(posedge clk); #1;
    check_eq("accept_ma", Ma, a);
    check_eq("accept_mwd", Mwd, exp_mwd);
    check_eq("busy_not_ready", req_ready, 0);
    if (pester) begin
      req_valid = 1'b1; req_we = 1'($urandom_range(0, 1));
      req_addr = a ^ 16'h0F0F; req_wdata = 16'($urandom);
    end else begin
      req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
      req_addr = 16'($urandom); req_wdata = 16'($urandom);
    end

    lat = 0; got = 0; mwen_seen = 0;
    while (!got && lat < 40) begin
      if (Mwen) mwen_seen = 1;
      if (pester) check_eq("busy_ma_hold", Ma, a);
      @(posedge clk); #1; lat++;
      if (rsp_valid) got = 1;
    end
    req_valid = 1'b0;

    check_eq("rsp_seen", got, 1);
    check_eq(we ? "wr_latency" : "rd_latency", lat, we ? WR_LAT : RD_LAT);
    if (!we) begin
      exp_rdata = exp_q.pop_front();
      check_eq("rd_mwen_low", mwen_seen, 0);
    end else begin
      check_eq("wr_mwen_seen", mwen_seen, 1);
    end
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("wr_err", wr_err, exp_err);
  endtask

  // ---------------- timeout ----------------
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic        r_we;
    logic [15:0] r_a, r_d;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = init_val(16'(i));
      ref_mem[i] = init_val(16'(i));
    end

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    mon_on = 1'b1;

    // reset state
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_ma", Ma, 16'h0);
    check_eq("rst_mwd", Mwd, 16'h0);
    check_eq("rst_mwen", Mwen, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 16'h0);
    check_eq("rst_wr_err", wr_err, 0);

    // directed: read, write then read-back, busy pestering, back-to-back
    do_req(1'b0, 16'h0001, 16'h0, 1'b0);
    do_req(1'b1, 16'h0200, 16'h1234, 1'b0);
    do_req(1'b0, 16'h0200, 16'h0, 1'b0);
    do_req(1'b0, 16'h0003, 16'h0, 1'b1);
    do_req(1'b0, 16'h0004, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 16'(16'h0100 + i), 16'h0, 1'b0);

    // read-only region: readback mismatch (when enabled) and no false clear
    do_req(1'b1, 16'h0100, 16'h5555, 1'b0);
    do_req(1'b1, 16'h0202, 16'h00AA, 1'b0);
    do_req(1'b0, 16'h0100, 16'h0, 1'b0);
    do_req(1'b0, 16'h0202, 16'h0, 1'b0);

    // top address
    do_req(1'b1, 16'hFFFF, 16'hA5C3, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       r_a = 16'(16'h0100 + $urandom_range(0, 7));
        1:       r_a = 16'hFFFF;
        default: r_a = 16'(16'h0300 + $urandom_range(0, 31));
      endcase
      r_d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      do_req(r_we, r_a, r_d, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a write pulse
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0201; req_wdata = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!Mwen && n < 10) begin @(posedge clk); #1; n++; end
    check_eq("rst_mid_mwen_rose", Mwen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_mid_mwen", Mwen, 0);
    check_eq("rst_mid_ma", Ma, 16'h0);
    check_eq("rst_mid_ready", req_ready, 1);
    check_eq("rst_mid_rsp_valid", rsp_valid, 0);
    check_eq("rst_mid_wr_err", wr_err, 0);
    exp_mwd = 16'h0; exp_rdata = 16'h0; exp_err = 1'b0;
    repeat (WR_LAT + 2) begin
      @(posedge clk); #1;
      check_eq("rst_mid_no_rsp", rsp_valid, 0);
    end

    // sequencer usable again after reset
    do_req(1'b0, 16'h0001, 16'h0, 1'b0);
    do_req(1'b1, 16'h0101, 16'h0F0F, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
